mux2x1_exerciser: RTL and testbench

- Synchronous self-checking stimulus/response stage wrapped around the 2:1 CMOS mux.
- Upstream role: drives {s, a1, a0} through all 8 input combinations.
- Downstream role: samples the mux output y after a programmable settle time, compares it against the expected value, and reports error count and first failing vector.
- Replaces free-running toggle stimulus with a clocked, repeatable, pass/fail sweep usable on both the switch-level and the gate-level mux.

---
 rtl/mux2x1_exerciser.sv | 142 ++++++++++++++
 tb/tb_mux2x1_exerciser.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mux2x1_exerciser.sv
// ---------------------------------------------------------------------------
// mux2x1_exerciser
// Clocked stimulus/response wrapper for a 2:1 mux under test. It sweeps
// {s,a1,a0} through 0..7 (PASSES times), holds each vector SETTLE cycles,
// then samples y for one CHECK cycle and compares it to the ideal mux result.
//
// Ports
//   clk              rising-edge clock
//   clrn             asynchronous active-low reset
//   start            begin a run (honoured only in IDLE or DONE)
//   y                mux output under test
//   s, a1, a0        mux stimulus, straight from the vector register
//   busy             run in progress (DRIVE or CHECK)
//   done             run finished (DONE)
//   pass             valid with done; 1 when no mismatch was seen
//   err_cnt          mismatch count, saturating at all-ones
//   first_fail       {s,a1,a0} of the first mismatching vector
//   first_fail_valid first_fail holds a captured vector
// ---------------------------------------------------------------------------
module mux2x1_exerciser #(
   parameter int SETTLE = 2,
   parameter int PASSES = 1,
   parameter int ERR_W  = 8
) (
   input  logic             clk,
   input  logic             clrn,
   input  logic             start,
   input  logic             y,
   output logic             s,
   output logic             a1,
   output logic             a0,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_cnt,
   output logic [2:0]       first_fail,
   output logic             first_fail_valid
);

   localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam int PW = (PASSES > 1) ? $clog2(PASSES) : 1;
   localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);
   localparam logic [PW-1:0] PASS_LAST   = PW'(PASSES - 1);

   typedef enum logic [1:0] {IDLE, DRIVE, CHECK, DONE} state_t;

   state_t           r_state;
   logic [2:0]       r_vec;
   logic [SW-1:0]    r_settle;
   logic [PW-1:0]    r_pass_cnt;
   logic [ERR_W-1:0] r_err_cnt;
   logic [2:0]       r_first_fail;
   logic             r_ff_valid;
   logic             r_busy;
   logic             r_done;
   logic             r_pass;

   logic             w_exp;
   logic             w_mis;
   logic [ERR_W-1:0] w_err_nxt;

   assign w_exp = r_vec[2] ? r_vec[1] : r_vec[0];
   // Case-inequality so an undriven or unknown y is reported as a failure.
   assign w_mis = (y !== w_exp);
   assign w_err_nxt = (w_mis && (r_err_cnt != '1)) ? r_err_cnt + ERR_W'(1) : r_err_cnt;

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         r_state      <= IDLE;
         r_vec        <= '0;
         r_settle     <= '0;
         r_pass_cnt   <= '0;
         r_err_cnt    <= '0;
         r_first_fail <= '0;
         r_ff_valid   <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_pass       <= 1'b0;
      end else begin
         case (r_state)
            IDLE, DONE: begin
               if (start) begin
                  r_state      <= DRIVE;
                  r_vec        <= '0;
                  r_settle     <= '0;
                  r_pass_cnt   <= '0;
                  r_err_cnt    <= '0;
                  r_first_fail <= '0;
                  r_ff_valid   <= 1'b0;
                  r_busy       <= 1'b1;
                  r_done       <= 1'b0;
                  r_pass       <= 1'b0;
               end
            end
            DRIVE: begin
               if (r_settle == SETTLE_LAST) begin
                  r_state  <= CHECK;
                  r_settle <= '0;
               end else begin
                  r_settle <= r_settle + SW'(1);
               end
            end
            CHECK: begin
               r_err_cnt <= w_err_nxt;
               if (w_mis && !r_ff_valid) begin
                  r_first_fail <= r_vec;
                  r_ff_valid   <= 1'b1;
               end
               if (r_vec == 3'd7) begin
                  r_vec <= '0;
                  if (r_pass_cnt == PASS_LAST) begin
                     // pass is taken from the post-update count so the final
                     // vector's result is included.
                     r_state <= DONE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                     r_pass  <= (w_err_nxt == '0);
                  end else begin
                     r_state    <= DRIVE;
                     r_pass_cnt <= r_pass_cnt + PW'(1);
                  end
               end else begin
                  r_state <= DRIVE;
                  r_vec   <= r_vec + 3'd1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign s                = r_vec[2];
   assign a1               = r_vec[1];
   assign a0               = r_vec[0];
   assign busy             = r_busy;
   assign done             = r_done;
   assign pass             = r_pass;
   assign err_cnt          = r_err_cnt;
   assign first_fail       = r_first_fail;
   assign first_fail_valid = r_ff_valid;

endmodule

// File: tb/tb_mux2x1_exerciser.sv
module tb_mux2x1_exerciser;

   typedef struct {
      int cnt;
      int ff;
      bit ffv;
      bit pass;
      int lat;
   } exp_t;

   logic clk = 1'b0;
   logic clrn = 1'b0;
   logic start = 1'b0;
   int   mode_r = 0;   // 0: correct mux, 1: y tied 0, 2: inverted mux

   int n_checks = 0;
   int n_errors = 0;

   exp_t q [3][$];

   // Three configurations: defaults, ERR_W=3, PASSES=3/SETTLE=1.
   logic       y0, s0, a1_0, a0_0, b0, d0, p0, v0;
   logic [7:0] e0;
   logic [2:0] f0;
   logic       y1, s1, a1_1, a0_1, b1, d1, p1, v1;
   logic [2:0] e1;
   logic [2:0] f1;
   logic       y2, s2, a1_2, a0_2, b2, d2, p2, v2;
   logic [7:0] e2;
   logic [2:0] f2;

   function automatic logic ymod(int m, logic s, logic a1, logic a0);
      logic e;
      e = s ? a1 : a0;
      if (m == 1) return 1'b0;
      if (m == 2) return ~e;
      return e;
   endfunction

   assign y0 = ymod(mode_r, s0, a1_0, a0_0);
   assign y1 = ymod(mode_r, s1, a1_1, a0_1);
   assign y2 = ymod(mode_r, s2, a1_2, a0_2);

   mux2x1_exerciser u0 (
      .clk(clk), .clrn(clrn), .start(start), .y(y0),
      .s(s0), .a1(a1_0), .a0(a0_0), .busy(b0), .done(d0), .pass(p0),
      .err_cnt(e0), .first_fail(f0), .first_fail_valid(v0));

   mux2x1_exerciser #(.ERR_W(3)) u1 (
      .clk(clk), .clrn(clrn), .start(start), .y(y1),
      .s(s1), .a1(a1_1), .a0(a0_1), .busy(b1), .done(d1), .pass(p1),
      .err_cnt(e1), .first_fail(f1), .first_fail_valid(v1));

   mux2x1_exerciser #(.SETTLE(1), .PASSES(3)) u2 (
      .clk(clk), .clrn(clrn), .start(start), .y(y2),
      .s(s2), .a1(a1_2), .a0(a0_2), .busy(b2), .done(d2), .pass(p2),
      .err_cnt(e2), .first_fail(f2), .first_fail_valid(v2));

   logic [2:0]  dn, bz, ps, fv;
   logic [31:0] ec [3];
   logic [31:0] ffa [3];
   logic [31:0] vec [3];
   assign dn = {d2, d1, d0};
   assign bz = {b2, b1, b0};
   assign ps = {p2, p1, p0};
   assign fv = {v2, v1, v0};
   assign ec[0] = {24'd0, e0};
   assign ec[1] = {29'd0, e1};
   assign ec[2] = {24'd0, e2};
   assign ffa[0] = {29'd0, f0};
   assign ffa[1] = {29'd0, f1};
   assign ffa[2] = {29'd0, f2};
   assign vec[0] = {29'd0, s0, a1_0, a0_0};
   assign vec[1] = {29'd0, s1, a1_1, a0_1};
   assign vec[2] = {29'd0, s2, a1_2, a0_2};

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Independent reference of one run's results.
   function automatic exp_t model(int m, int passes, int settle, int errw);
      exp_t r;
      int   maxv;
      bit   e, yv;
      r.cnt = 0; r.ff = 0; r.ffv = 0;
      maxv = (1 << errw) - 1;
      for (int p = 0; p < passes; p++)
         for (int v = 0; v < 8; v++) begin
            e  = v[2] ? v[1] : v[0];
            yv = (m == 0) ? e : (m == 1) ? 1'b0 : !e;
            if (yv != e) begin
               if (r.cnt < maxv) r.cnt++;
               if (!r.ffv) begin r.ff = v; r.ffv = 1; end
            end
         end
      r.pass = (r.cnt == 0);
      r.lat  = 8 * passes * (settle + 1);
      return r;
   endfunction

   task automatic check_idle(input string tag);
      for (int d = 0; d < 3; d++) begin
         chk({tag, "_busy"}, {31'd0, bz[d]}, 0);
         chk({tag, "_done"}, {31'd0, dn[d]}, 0);
         chk({tag, "_pass"}, {31'd0, ps[d]}, 0);
         chk({tag, "_err"}, ec[d], 0);
         chk({tag, "_ff"}, ffa[d], 0);
         chk({tag, "_ffv"}, {31'd0, fv[d]}, 0);
         chk({tag, "_vec"}, vec[d], 0);
      end
   endtask

   // Pulse start (sampled at edge 0); then at the negedge after edge n,
   // compare dut0's stimulus sequence and pop/compare results as each done rises.
   task automatic run(input int m, input int restart_at);
      bit   seen [3];
      exp_t e;
      mode_r = m;
      q[0].push_back(model(m, 1, 2, 8));
      q[1].push_back(model(m, 1, 2, 3));
      q[2].push_back(model(m, 3, 1, 8));
      seen = '{0, 0, 0};
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      for (int n = 0; n <= 100; n++) begin
         start = (n == restart_at);
         if (n < 24) begin
            chk("vec_seq", vec[0], n / 3);
            chk("busy_run", {31'd0, b0}, 1);
            chk("done_early", {31'd0, d0}, 0);
         end
         for (int d = 0; d < 3; d++) begin
            if (!seen[d] && dn[d]) begin
               e = q[d].pop_front();
               seen[d] = 1;
               chk("latency", n, e.lat);
               chk("err_cnt", ec[d], e.cnt);
               chk("first_fail", ffa[d], e.ff);
               chk("ff_valid", {31'd0, fv[d]}, {31'd0, e.ffv});
               chk("pass", {31'd0, ps[d]}, {31'd0, e.pass});
               chk("busy_done", {31'd0, bz[d]}, 0);
               chk("vec_wrap", vec[d], 0);
            end
         end
         if (seen[0] && seen[1] && seen[2]) break;
         if (n == 100) begin
            chk("timeout_done", 0, 1);
            for (int d = 0; d < 3; d++) q[d].delete();
         end
         @(negedge clk);
      end
      start = 1'b0;
   endtask

   initial begin
      #1;
      check_idle("reset");
      @(negedge clk);
      clrn = 1'b1;
      @(negedge clk);
      check_idle("idle");

      run(0, -1);   // clean run from IDLE
      run(1, -1);   // y tied 0, started from DONE
      run(2, -1);   // inverted y, saturation on ERR_W=3
      run(0, 5);    // restart mid-run ignored; DONE start clears prior errors

      // Abort mid-run with clrn.
      mode_r = 1;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      for (int n = 0; n < 10; n++) @(negedge clk);
      chk("pre_abort_busy", {31'd0, b0}, 1);
      clrn = 1'b0;
      #1;
      check_idle("abort");
      @(posedge clk);
      #1;
      check_idle("abort_held");
      @(negedge clk);
      clrn = 1'b1;
      for (int n = 0; n < 30; n++) @(negedge clk);
      check_idle("abort_stays_idle");

      run(0, -1);   // full clean run after the abort

      chk("queue_empty", q[0].size() + q[1].size() + q[2].size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
